// File: rtl/move_decode_if.sv
// Bundles the PS/2 byte stream, the move enable and the decoded move/held
// outputs that pass between the keyboard front end and the player stage.
interface move_decode_if;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       en;
  logic [3:0] move;
  logic [3:0] held;

  modport master (
    output ps2_data,
    output ps2_valid,
    output en,
    input  move,
    input  held
  );

  modport slave (
    input  ps2_data,
    input  ps2_valid,
    input  en,
    output move,
    output held
  );
endinterface

// File: rtl/move_decode.sv
// PS/2 scan-code to direction decoder with held-key tracking and auto-repeat.
// Bit order for move/held: bit0 up, bit1 down, bit2 left, bit3 right.
module move_decode #(
  parameter int unsigned REPEAT_DELAY  = 10_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic          clk,
  input  logic          rstn,
  move_decode_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]       PFX_EXT   = 8'hE0;
  localparam logic [7:0]       PFX_BRK   = 8'hF0;
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD);

  state_t           state;
  state_t           state_nxt;
  logic             code_vld;
  logic             code_ext;
  logic             code_brk;
  logic [3:0]       dir_oh;
  logic             new_press;
  logic [3:0]       held_nxt;
  logic [3:0]       held_reg;
  logic [3:0]       move_reg;
  logic [1:0]       rep_dir;
  logic [CNT_W-1:0] cnt;

  // Map a scan code to a one-hot direction; keypad and unknown codes map to 0.
  function automatic logic [3:0] dir_decode(input logic [7:0] code, input logic ext);
    logic [3:0] d;
    d = 4'b0000;
    if (!ext) begin
      case (code)
        8'h1D:   d = 4'b0001;
        8'h1B:   d = 4'b0010;
        8'h1C:   d = 4'b0100;
        8'h23:   d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h75:   d = 4'b0001;
        8'h72:   d = 4'b0010;
        8'h6B:   d = 4'b0100;
        8'h74:   d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end
    return d;
  endfunction

  function automatic logic [1:0] dir_index(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Prefix tracking state register; reset drops any partial code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and code classification: prefixes advance, anything else is a code.
  always_comb begin
    state_nxt = state;
    code_vld  = 1'b0;
    code_ext  = 1'b0;
    code_brk  = 1'b0;
    if (bus.ps2_valid) begin
      case (state)
        IDLE: begin
          if (bus.ps2_data == PFX_EXT)      state_nxt = EXT;
          else if (bus.ps2_data == PFX_BRK) state_nxt = BRK;
          else begin
            code_vld  = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT: begin
          if (bus.ps2_data == PFX_EXT)      state_nxt = EXT;
          else if (bus.ps2_data == PFX_BRK) state_nxt = EXT_BRK;
          else begin
            code_vld  = 1'b1;
            code_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          if (bus.ps2_data == PFX_BRK) state_nxt = BRK;
          else begin
            code_vld  = 1'b1;
            code_brk  = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT_BRK: begin
          if (bus.ps2_data == PFX_BRK) state_nxt = EXT_BRK;
          else begin
            code_vld  = 1'b1;
            code_ext  = 1'b1;
            code_brk  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Only a make of a direction not already held counts as a press; typematic
  // makes fall through so the running repeat timer is left alone.
  assign dir_oh    = code_vld ? dir_decode(bus.ps2_data, code_ext) : 4'b0000;
  assign new_press = !code_brk && ((dir_oh & ~held_reg) != 4'b0000);
  assign held_nxt  = new_press ? (held_reg | dir_oh) :
                     code_brk  ? (held_reg & ~dir_oh) : held_reg;

  // Held/repeat registers and the registered move pulse; a new press wins over
  // a coinciding repeat expiry, and en only masks the pulse itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held_reg <= 4'b0000;
      move_reg <= 4'b0000;
      rep_dir  <= 2'd0;
      cnt      <= '0;
    end else begin
      held_reg <= held_nxt;
      move_reg <= 4'b0000;
      if (new_press) begin
        rep_dir <= dir_index(dir_oh);
        cnt     <= DELAY_LD;
        if (bus.en) move_reg <= dir_oh;
      end else if (held_nxt[rep_dir]) begin
        if (cnt < CNT_W'(2)) begin
          cnt <= PERIOD_LD;
          if (bus.en) move_reg <= 4'b0001 << rep_dir;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  assign bus.move = move_reg;
  assign bus.held = held_reg;

endmodule

// File: tb/tb_move_decode.sv
// Scoreboard bench for move_decode with short repeat timing (delay 8, period 4).
module tb_move_decode;

  typedef struct {
    int unsigned at;
    logic [3:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int unsigned cyc = 0;
  int unsigned sent_at = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];

  move_decode_if bus();

  move_decode #(
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .CNT_W         (24)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle index: a byte driven while cyc==s shows its pulse at cyc==s+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    sent_at = cyc;
    bus.ps2_data  = b;
    bus.ps2_valid = 1'b1;
    tick();
    bus.ps2_valid = 1'b0;
    bus.ps2_data  = 8'h00;
  endtask

  task automatic expect_pulse(input int unsigned at, input logic [3:0] val);
    exp_t e;
    e.at  = at;
    e.val = val;
    sb.push_back(e);
  endtask

  // Every cycle, move must equal the scheduled pulse for that cycle or zero.
  always @(negedge clk) begin
    logic [3:0] exp_mv;
    exp_mv = 4'b0000;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      check_eq("missed_pulse", 8'h00, {4'b0000, sb[0].val});
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].at == cyc) begin
      exp_mv = sb[0].val;
      void'(sb.pop_front());
    end
    check_eq("move", {4'b0000, bus.move}, {4'b0000, exp_mv});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c;
    bus.ps2_data  = 8'h00;
    bus.ps2_valid = 1'b0;
    bus.en        = 1'b1;

    idle(3);
    check_eq("rst_held", {4'b0000, bus.held}, 8'h00);
    check_eq("rst_move", {4'b0000, bus.move}, 8'h00);
    rstn = 1'b1;
    idle(4);

    // Plain make then break of up.
    send(8'h1D);
    expect_pulse(sent_at + 1, 4'b0001);
    check_eq("up_held", {4'b0000, bus.held}, 8'h01);
    send(8'hF0);
    send(8'h1D);
    check_eq("up_break", {4'b0000, bus.held}, 8'h00);
    idle(12);

    // Extended right held: press pulse plus repeats at +9, +13, +17.
    send(8'hE0);
    send(8'h74);
    c = sent_at;
    expect_pulse(c + 1, 4'b1000);
    expect_pulse(c + 9, 4'b1000);
    expect_pulse(c + 13, 4'b1000);
    expect_pulse(c + 17, 4'b1000);
    check_eq("right_held", {4'b0000, bus.held}, 8'h08);
    idle(16);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    check_eq("right_break", {4'b0000, bus.held}, 8'h00);
    idle(10);

    // Keypad code ignored, extended code of the same value decoded.
    send(8'h75);
    check_eq("keypad_held", {4'b0000, bus.held}, 8'h00);
    idle(2);
    send(8'hE0);
    send(8'h75);
    expect_pulse(sent_at + 1, 4'b0001);
    check_eq("ext_up_held", {4'b0000, bus.held}, 8'h01);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_eq("ext_up_break", {4'b0000, bus.held}, 8'h00);
    idle(10);

    // Left then right: repeat follows the newest press, no fallback on release.
    send(8'h1C);
    expect_pulse(sent_at + 1, 4'b0100);
    send(8'h23);
    c = sent_at;
    expect_pulse(c + 1, 4'b1000);
    expect_pulse(c + 9, 4'b1000);
    expect_pulse(c + 13, 4'b1000);
    check_eq("two_held", {4'b0000, bus.held}, 8'h0C);
    idle(12);
    send(8'hF0);
    send(8'h23);
    check_eq("left_only", {4'b0000, bus.held}, 8'h04);
    idle(12);
    send(8'hF0);
    send(8'h1C);
    check_eq("none_held", {4'b0000, bus.held}, 8'h00);
    idle(4);

    // Press with en low, enable before expiry, typematic makes ignored.
    bus.en = 1'b0;
    send(8'h1B);
    c = sent_at;
    check_eq("down_held_en0", {4'b0000, bus.held}, 8'h02);
    idle(2);
    bus.en = 1'b1;
    send(8'h1B);
    send(8'h1B);
    expect_pulse(c + 9, 4'b0010);
    expect_pulse(c + 13, 4'b0010);
    idle(8);
    send(8'hF0);
    send(8'h1B);
    check_eq("down_break", {4'b0000, bus.held}, 8'h00);
    idle(10);

    // New press landing on the repeat expiry cycle replaces the repeat pulse.
    send(8'h1D);
    c = sent_at;
    expect_pulse(c + 1, 4'b0001);
    idle(7);
    send(8'h1C);
    expect_pulse(c + 9, 4'b0100);
    expect_pulse(c + 17, 4'b0100);
    idle(8);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h1D);
    check_eq("collide_break", {4'b0000, bus.held}, 8'h00);
    idle(10);

    // Repeated prefixes collapse onto one.
    send(8'hE0);
    send(8'hE0);
    send(8'h6B);
    expect_pulse(sent_at + 1, 4'b0100);
    send(8'hE0);
    send(8'hF0);
    send(8'hF0);
    send(8'h6B);
    check_eq("dbl_prefix", {4'b0000, bus.held}, 8'h00);
    idle(10);

    // Asynchronous reset after an E0 prefix drops held keys and the prefix.
    send(8'h1D);
    expect_pulse(sent_at + 1, 4'b0001);
    send(8'hE0);
    check_eq("pre_rst_held", {4'b0000, bus.held}, 8'h01);
    rstn = 1'b0;
    #2;
    check_eq("async_held", {4'b0000, bus.held}, 8'h00);
    check_eq("async_move", {4'b0000, bus.move}, 8'h00);
    tick();
    rstn = 1'b1;
    idle(2);
    send(8'h72);
    check_eq("post_rst_held", {4'b0000, bus.held}, 8'h00);
    idle(12);

    check_eq("sb_empty", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_decode.md
MOVE_DECODE -- requirements
Module: move_decode

Interface
REQ-001 Parameter REPEAT_DELAY, default 10_000_000, clk cycles from press pulse to first auto-repeat pulse (0.4 s at 25 MHz).
REQ-002 Parameter REPEAT_PERIOD, default 2_500_000, clk cycles between successive auto-repeat pulses.
REQ-003 Parameter CNT_W, default 24, repeat counter width; both delay parameters SHALL fit in CNT_W bits.
REQ-004 clk  input  1  system clock, same clock domain as the player stage.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 ps2_data  input  8  received PS/2 scan-code byte, valid only with ps2_valid.
REQ-007 ps2_valid  input  1  one-cycle strobe; one byte per strobe.
REQ-008 en  input  1  move-output enable; low suppresses move pulses only.
REQ-009 move  output  4  one-hot, one-cycle move request: bit0 up, bit1 down, bit2 left, bit3 right; feeds the player stage.
REQ-010 held  output  4  level: direction keys currently held, same bit order as move.

Function
REQ-011 The decoder SHALL be an FSM with states IDLE, EXT (E0 received), BRK (F0 received), EXT_BRK (E0 then F0 received), advancing only on ps2_valid.
REQ-012 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte in any state SHALL be consumed as a code and return the FSM to IDLE.
REQ-013 Make codes: non-extended 1D up, 1B down, 1C left, 23 right; extended (after E0) 75 up, 72 down, 6B left, 74 right.
REQ-014 Non-extended 75/72/6B/74 (keypad) and all unlisted codes SHALL be ignored with no change to held or move.
REQ-015 Make of a direction not yet held: set its held bit and pulse that move bit the cycle after the ps2_valid cycle (latency 1).
REQ-016 Make of a direction already held (keyboard typematic) SHALL produce no pulse and no timer restart.
REQ-017 Break (code after F0 / E0 F0) SHALL clear the matching held bit with no pulse; break of an unheld direction SHALL be ignored.
REQ-018 Repeat owner: register rep_dir, set to the most recently newly-pressed direction; a press SHALL load the counter with REPEAT_DELAY.
REQ-019 While held[rep_dir] is set the counter SHALL decrement each cycle; on reaching 0 the cycle's move SHALL pulse rep_dir and the counter reloads REPEAT_PERIOD.
REQ-020 Releasing rep_dir SHALL stop repeat; no fallback to other still-held keys until a new press.
REQ-021 Press coinciding with repeat expiry: only the new press pulse is issued, the counter reloads REPEAT_DELAY.
REQ-022 move SHALL be registered and carry at most one set bit in any cycle.
REQ-023 en low: held, rep_dir and counter keep updating; move SHALL be 0000; no pulse is deferred to when en returns high.
REQ-024 An E0 or F0 prefix followed by another prefix: E0 in EXT stays EXT; F0 in BRK/EXT_BRK stays in that state.

Reset
REQ-025 rstn low SHALL asynchronously force state IDLE, move 0000, held 0000, rep_dir 0, counter 0.
REQ-026 Reset mid-sequence (e.g. after E0) SHALL discard the partial code; the next byte is decoded from IDLE.
REQ-027 After rstn deassertion no pulse SHALL occur until a valid make code is received.

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=4, en=1 unless stated)
REQ-028 Byte 1D -> move=0001 for exactly one cycle, held=0001; bytes F0,1D -> held=0000, no pulse.
REQ-029 Bytes E0,74 and hold -> move=1000 at +1, repeat pulses at +9, +13, +17; bytes E0,F0,74 -> held=0000, no further pulses.
REQ-030 Byte 75 alone -> no pulse, held unchanged; then E0,75 -> move=0001.
REQ-031 Press 1C, then 23 while 1C held -> pulses 0100 then 1000; repeats are 1000 only; break 23 -> repeats stop, held=0100.
REQ-032 Press 1B with en=0 -> move stays 0000, held=0010; raise en before delay expires -> first pulse 0010 at repeat expiry; repeated 1B make bytes -> no extra pulses.
REQ-033 Assert rstn low after E0 received -> all outputs 0; then byte 72 -> ignored (non-extended), no pulse.
